// File: rtl/mul_defs_pkg.sv
// mul_defs: shared multiplier FSM state encodings and radix-4 Booth digit codes.
// Reused by the ALU decode so both sides agree on the encodings.
package mul_defs;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;
    localparam logic [2:0] BOOTH_Z0  = 3'b000;
    localparam logic [2:0] BOOTH_P1A = 3'b001;
    localparam logic [2:0] BOOTH_P1B = 3'b010;
    localparam logic [2:0] BOOTH_P2  = 3'b011;
    localparam logic [2:0] BOOTH_M2  = 3'b100;
    localparam logic [2:0] BOOTH_M1A = 3'b101;
    localparam logic [2:0] BOOTH_M1B = 3'b110;
    localparam logic [2:0] BOOTH_Z1  = 3'b111;
    typedef struct packed {
        logic zero;
        logic neg;
        logic dbl;
    } booth_sel_t;
endpackage

// File: rtl/booth_recode.sv
// booth_recode: maps one overlapping 3-bit multiplier window to a Booth select.
// Ports: bits_i - {b[2k+1], b[2k], b[2k-1]}; sel_o - {zero, neg, double}.
module booth_recode
    import mul_defs::*;
(
    input  logic [2:0] bits_i,
    output booth_sel_t sel_o
);
    assign sel_o.zero = (bits_i == BOOTH_Z0) || (bits_i == BOOTH_Z1);
    assign sel_o.neg  = bits_i[2] && (bits_i != BOOTH_Z1);
    assign sel_o.dbl  = (bits_i == BOOTH_P2) || (bits_i == BOOTH_M2);
endmodule

// File: rtl/mul_ctrl.sv
// mul_ctrl: iterative radix-4 Booth signed multiplier, one digit per cycle.
// Ports: clk, clr (sync active-high reset), start/a/b (request and operands),
//        ready (idle), busy (RUN or DONE), done (one-cycle result pulse),
//        cHI/cLOW (registered upper/lower product halves).
module mul_ctrl
    import mul_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = WIDTH / 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] cHI,
    output logic [WIDTH-1:0] cLOW
);
    localparam int CW = $clog2(ITERS);
    localparam int PW = 2 * WIDTH;

    mul_state_e      state_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   mcand_q;
    logic [WIDTH:0]  mplr_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   mult;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   acc_d;
    booth_sel_t      sel;

    // mcand_q is pre-shifted by 2k and mplr_q shifts right so its low three
    // bits are always the current Booth window, with b[-1]=0 appended below.
    booth_recode u_recode (
        .bits_i(mplr_q[2:0]),
        .sel_o (sel)
    );

    always_comb begin
        mult   = sel.zero ? '0 : (sel.dbl ? {mcand_q[PW-2:0], 1'b0} : mcand_q);
        addend = sel.neg ? -mult : mult;
        acc_d  = acc_q + addend;
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == RUN) || (state_q == DONE);

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cHI     <= '0;
            cLOW    <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    mcand_q <= {{WIDTH{a[WIDTH-1]}}, a};
                    mplr_q  <= {b, 1'b0};
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    acc_q   <= acc_d;
                    mcand_q <= mcand_q << 2;
                    mplr_q  <= mplr_q >> 2;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CW'(ITERS - 1)) begin
                        cHI     <= acc_d[PW-1:WIDTH];
                        cLOW    <= acc_d[WIDTH-1:0];
                        done    <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mul_ctrl.md
MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 SHALL expose parameter WIDTH, default 32, operand width; only 32 is supported.
REQ-002 SHALL expose parameter ITERS, default WIDTH/2 (16), the number of radix-4 Booth digit cycles.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 SHALL have port clr, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to begin a signed multiply.
REQ-006 SHALL have port a, input, 32, signed multiplicand.
REQ-007 SHALL have port b, input, 32, signed multiplier.
REQ-008 SHALL have port ready, output, 1, high only in IDLE; start is accepted when start&ready.
REQ-009 SHALL have port busy, output, 1, high in RUN and DONE; the CPU stalls HI/LO readers on it.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when cHI/cLOW hold a new product.
REQ-011 SHALL have ports cHI and cLOW, output, 32 each, registered upper and lower product halves.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE.
REQ-013 SHALL, in IDLE with start=1, capture a and b into internal registers, clear the 64-bit accumulator, set digit count to 0 and go to RUN.
REQ-014 SHALL, in each RUN cycle k (0..15), recode digit {b[2k+1], b[2k], b[2k-1]}, with b[-1]=0, into 000/111->0, 001/010->+A, 011->+2A, 100->-2A, 101/110->-A.
REQ-015 SHALL define A as a sign-extended to 64 bits and shifted left by 2k, and SHALL add the selected multiple to the accumulator modulo 2^64.
REQ-016 SHALL increment the count each RUN cycle and go to DONE after the cycle with k=15.
REQ-017 SHALL, on entry to DONE, load cHI with accumulator[63:32] and cLOW with accumulator[31:0], assert done for exactly that cycle, and return to IDLE next.
REQ-018 SHALL give a fixed latency: start accepted at edge T results in done=1 during cycle T+17, independent of operand values.
REQ-019 SHALL ignore start while busy; captured operands SHALL NOT change when a or b change mid-operation.
REQ-020 SHALL hold cHI/cLOW unchanged outside the DONE load, including across ignored starts.
REQ-021 SHALL accept a start asserted in the cycle immediately after DONE, giving a back-to-back rate of one product per 18 cycles.
REQ-022 SHALL produce the exact two's-complement 64-bit product for all inputs, including 0x80000000 operands.

Reset
REQ-023 SHALL, when clr=1 at a clock edge, force IDLE, count=0, accumulator=0, cHI=0, cLOW=0, done=0 and ready=1, overriding start in the same cycle.
REQ-024 SHALL, on clr during RUN or DONE, abort the operation; no done pulse SHALL follow and cHI/cLOW SHALL read 0.

Structure
REQ-025 SHALL take state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and Booth digit codes from a shared package/include mul_defs, reused by the ALU decode.
REQ-026 SHALL instantiate one combinational sub-module, booth_recode, mapping 3 multiplier bits to a select {zero, neg, double}.
REQ-027 SHALL keep the adder, accumulator, counter and FSM in mul_ctrl, with no combinational path from start to ready, done, cHI or cLOW.

Verification
REQ-028 Bench SHALL drive a=3, b=4, start at T, and require done at T+17 with cHI=0x00000000 and cLOW=0x0000000C.
REQ-029 Bench SHALL drive a=0xFFFFFFFF (-1), b=1, and require cHI=0xFFFFFFFF and cLOW=0xFFFFFFFF.
REQ-030 Bench SHALL drive a=b=0x80000000, and require cHI=0x40000000 and cLOW=0x00000000.
REQ-031 Bench SHALL drive a=b=0x7FFFFFFF, toggle a/b and pulse start during RUN, and require cHI=0x3FFFFFFF, cLOW=0x00000001 and exactly one done.
REQ-032 Bench SHALL pulse clr at T+8 of an operation, and require no done, cHI=cLOW=0 and ready=1 at T+9.
REQ-033 Bench SHALL issue back-to-back starts (3*4 then -5*7) and require done pulses 18 cycles apart with the second result cHI=0xFFFFFFFF and cLOW=0xFFFFFFDD.
